// File: rtl/ahb3lite_apb_bridge_if.sv
// Signal bundle between an AHB3-Lite segment and one APB segment.
// The bridge uses the slave modport; the surrounding fabric or bench uses the master modport.
interface ahb3lite_apb_bridge_if #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int PADDR_SIZE = 10
);
    // AHB3-Lite side
    logic                    hsel;
    logic [HADDR_SIZE-1:0]   haddr;
    logic [HDATA_SIZE-1:0]   hwdata;
    logic [HDATA_SIZE-1:0]   hrdata;
    logic                    hwrite;
    logic [2:0]              hsize;
    logic [2:0]              hburst;
    logic [3:0]              hprot;
    logic [1:0]              htrans;
    logic                    hmastlock;
    logic                    hready;
    logic                    hreadyout;
    logic                    hresp;

    // APB side
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [2:0]              pprot;
    logic [PADDR_SIZE-1:0]   paddr;
    logic [HDATA_SIZE-1:0]   pwdata;
    logic [HDATA_SIZE/8-1:0] pstrb;
    logic [HDATA_SIZE-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

    modport slave (
        input  hsel, haddr, hwdata, hwrite, hsize, hburst, hprot, htrans, hmastlock, hready,
        output hrdata, hreadyout, hresp,
        output psel, penable, pwrite, pprot, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport master (
        output hsel, haddr, hwdata, hwrite, hsize, hburst, hprot, htrans, hmastlock, hready,
        input  hrdata, hreadyout, hresp,
        input  psel, penable, pwrite, pprot, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/ahb3lite_apb_bridge.sv
// AHB3-Lite slave to APB3/APB4 master bridge: one AHB beat becomes one APB SETUP+ACCESS transfer.
// Optional ACCESS-phase timeout is built in when AHB3LITE_APB_TIMEOUT_EN is defined.
module ahb3lite_apb_bridge #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int PADDR_SIZE = 10,
    parameter int TIMEOUT    = 255
) (
    input  logic                 i_hclk,
    input  logic                 i_hresetn,
    ahb3lite_apb_bridge_if.slave io_bus
);
    localparam int         NBYTES    = HDATA_SIZE / 8;
    localparam int         LANE_BITS = $clog2(NBYTES);
    localparam logic [2:0] MAX_SIZE  = 3'(LANE_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_SETUP,
        S_ACCESS,
        S_ERR1
    } state_t;

    state_t                  r_state;
    logic                    r_hreadyout;
    logic                    r_hresp;
    logic [HDATA_SIZE-1:0]   r_hrdata;
    logic                    r_psel;
    logic                    r_penable;
    logic                    r_pwrite;
    logic [2:0]              r_pprot;
    logic [PADDR_SIZE-1:0]   r_paddr;
    logic [HDATA_SIZE-1:0]   r_pwdata;
    logic [NBYTES-1:0]       r_pstrb;

    logic                    w_accept;
    logic                    w_size_err;
    logic [HADDR_SIZE-1:0]   w_byte_off;
    logic [NBYTES-1:0]       w_strb;
    logic [2:0]              w_pprot;
    logic                    w_tmo_hit;
    logic                    w_unused;

    assign w_accept   = io_bus.hsel & io_bus.hready & io_bus.htrans[1];
    assign w_size_err = (io_bus.hsize > MAX_SIZE);
    assign w_byte_off = io_bus.haddr & HADDR_SIZE'(NBYTES - 1);
    assign w_pprot    = {~io_bus.hprot[0], 1'b1, io_bus.hprot[1]};

    // A lane is enabled when it falls in the same size-aligned block as the byte address.
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_strb
        assign w_strb[gi] = ((HADDR_SIZE'(gi) >> io_bus.hsize) == (w_byte_off >> io_bus.hsize));
    end

    // Burst type, lock and the cacheable/bufferable HPROT bits have no APB counterpart.
    assign w_unused = ^{io_bus.hburst, io_bus.hmastlock, io_bus.hprot[3:2], io_bus.haddr};

`ifdef AHB3LITE_APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_tmo_cnt;

    always_ff @(posedge i_hclk or negedge i_hresetn) begin
        if (!i_hresetn) begin
            r_tmo_cnt <= '0;
        end else if (r_state != S_ACCESS || io_bus.pready) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Fires in the TIMEOUT-th ACCESS cycle that still sees PREADY low.
    assign w_tmo_hit = (r_tmo_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge i_hclk or negedge i_hresetn) begin
        if (!i_hresetn) begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_hrdata    <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_pprot     <= '0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b0;
                    r_psel      <= 1'b0;
                    r_penable   <= 1'b0;
                    if (w_accept) begin
                        r_hreadyout <= 1'b0;
                        if (w_size_err) begin
                            r_hresp <= 1'b1;
                            r_state <= S_ERR1;
                        end else begin
                            r_paddr  <= io_bus.haddr[PADDR_SIZE-1:0];
                            r_pwrite <= io_bus.hwrite;
                            r_pprot  <= w_pprot;
                            r_pstrb  <= io_bus.hwrite ? w_strb : '0;
                            if (io_bus.hwrite) begin
                                r_state <= S_WDATA;
                            end else begin
                                r_psel  <= 1'b1;
                                r_state <= S_SETUP;
                            end
                        end
                    end
                end

                // HWDATA is only valid in the AHB data phase, one cycle after accept.
                S_WDATA: begin
                    r_pwdata <= io_bus.hwdata;
                    r_psel   <= 1'b1;
                    r_state  <= S_SETUP;
                end

                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
                end

                S_ACCESS: begin
                    if (io_bus.pready) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        if (io_bus.pslverr) begin
                            r_hresp <= 1'b1;
                            r_state <= S_ERR1;
                        end else begin
                            if (!r_pwrite) begin
                                r_hrdata <= io_bus.prdata;
                            end
                            r_hreadyout <= 1'b1;
                            r_hresp     <= 1'b0;
                            r_state     <= S_IDLE;
                        end
                    end else if (w_tmo_hit) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_hresp   <= 1'b1;
                        r_state   <= S_ERR1;
                    end
                end

                // Second cycle of the two-cycle ERROR response happens in IDLE.
                S_ERR1: begin
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b1;
                    r_state     <= S_IDLE;
                end

                default: begin
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b0;
                    r_psel      <= 1'b0;
                    r_penable   <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign io_bus.hreadyout = r_hreadyout;
    assign io_bus.hresp     = r_hresp;
    assign io_bus.hrdata    = r_hrdata;
    assign io_bus.psel      = r_psel;
    assign io_bus.penable   = r_penable;
    assign io_bus.pwrite    = r_pwrite;
    assign io_bus.pprot     = r_pprot;
    assign io_bus.paddr     = r_paddr;
    assign io_bus.pwdata    = r_pwdata;
    assign io_bus.pstrb     = r_pstrb;
endmodule

// File: tb/tb_ahb3lite_apb_bridge.sv
// Directed self-checking bench for ahb3lite_apb_bridge with a small configurable APB responder.
`timescale 1ns/1ps
module tb_ahb3lite_apb_bridge;
    localparam int HA  = 32;
    localparam int HD  = 32;
    localparam int PA  = 10;
    localparam int TMO = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ahb3lite_apb_bridge_if #(.HADDR_SIZE(HA), .HDATA_SIZE(HD), .PADDR_SIZE(PA)) bus ();

    ahb3lite_apb_bridge #(
        .HADDR_SIZE(HA),
        .HDATA_SIZE(HD),
        .PADDR_SIZE(PA),
        .TIMEOUT   (TMO)
    ) dut (
        .i_hclk   (clk),
        .i_hresetn(rst_n),
        .io_bus   (bus)
    );

    // Single-slave segment: the bus-wide ready is this slave's ready.
    assign bus.hready = bus.hreadyout;

    int checks = 0;
    int errors = 0;

    // APB responder: PREADY rises after stall_cfg ACCESS cycles unless stuck.
    int          stall_cfg = 0;
    logic        stuck     = 1'b0;
    logic        err_cfg   = 1'b0;
    logic [31:0] rdata_cfg = 32'h0;
    int          acc_cnt   = 0;

    always @(posedge clk) begin
        acc_cnt <= (bus.psel && bus.penable) ? acc_cnt + 1 : 0;
    end
    assign bus.pready  = !stuck && (acc_cnt >= stall_cfg);
    assign bus.pslverr = err_cfg;
    assign bus.prdata  = rdata_cfg;

    // Per-transaction observations.
    int          x_low;
    int          x_err_low;
    int          x_acc;
    logic        x_saw_psel;
    logic        x_first_setup;
    logic        x_resp;
    logic [31:0] x_rdata;
    logic [PA-1:0] s_paddr;
    logic [3:0]  s_pstrb;
    logic [31:0] s_pwdata;
    logic [2:0]  s_pprot;
    logic        s_pwrite;

    // Called at a negedge with HREADYOUT high; returns at the negedge of the completion cycle.
    task do_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                 input logic [3:0] prot, input logic [31:0] wdata);
        int c;
        bus.hsel   = 1'b1;
        bus.haddr  = addr;
        bus.hwrite = wr;
        bus.hsize  = size;
        bus.hprot  = prot;
        bus.htrans = 2'b10;
        @(negedge clk);
        bus.hsel   = 1'b0;
        bus.htrans = 2'b00;
        bus.hwdata = wdata;
        x_low = 0; x_err_low = 0; x_acc = 0;
        x_saw_psel = 1'b0; x_first_setup = 1'b0;
        c = 0;
        while (bus.hreadyout !== 1'b1 && c < 2000) begin
            if (c == 0 && bus.psel && !bus.penable) x_first_setup = 1'b1;
            if (bus.psel && !bus.penable && !x_saw_psel) begin
                s_paddr  = bus.paddr;
                s_pstrb  = bus.pstrb;
                s_pwdata = bus.pwdata;
                s_pprot  = bus.pprot;
                s_pwrite = bus.pwrite;
            end
            if (bus.psel) x_saw_psel = 1'b1;
            if (bus.psel && bus.penable) x_acc++;
            if (bus.hresp) x_err_low++;
            x_low++;
            c++;
            @(negedge clk);
        end
        checks++;
        if (bus.hreadyout !== 1'b1) begin
            errors++;
            $display("FAIL xfer_bound: hreadyout=%b after %0d cycles, required 1", bus.hreadyout, c);
        end
        x_resp  = bus.hresp;
        x_rdata = bus.hrdata;
        $display("xfer addr=%h wr=%0d size=%0d low=%0d acc=%0d resp=%b hrdata=%h paddr=%h pstrb=%b",
                 addr, wr, size, x_low, x_acc, x_resp, x_rdata, s_paddr, s_pstrb);
    endtask

    task test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0) begin
            errors++;
            $display("FAIL reset_ahb: hreadyout=%b hresp=%b, required 1 0", bus.hreadyout, bus.hresp);
        end
        checks++;
        if (bus.hrdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_hrdata: got %h, required 0", bus.hrdata);
        end
        checks++;
        if ({bus.psel, bus.penable, bus.pwrite} !== 3'b000) begin
            errors++;
            $display("FAIL reset_apb_ctrl: psel/penable/pwrite=%b, required 000",
                     {bus.psel, bus.penable, bus.pwrite});
        end
        checks++;
        if (bus.paddr !== '0 || bus.pwdata !== '0 || bus.pstrb !== '0 || bus.pprot !== '0) begin
            errors++;
            $display("FAIL reset_apb_data: paddr=%h pwdata=%h pstrb=%b pprot=%b, required all 0",
                     bus.paddr, bus.pwdata, bus.pstrb, bus.pprot);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task test_word_write;
        do_xfer(32'h104, 1'b1, 3'd2, 4'b0011, 32'hDEADBEEF);
        checks++;
        if (x_low !== 3) begin
            errors++; $display("FAIL wr_wait: hreadyout low %0d cycles, required 3", x_low);
        end
        checks++;
        if (s_paddr !== 10'h104) begin
            errors++; $display("FAIL wr_paddr: got %h, required 104", s_paddr);
        end
        checks++;
        if (s_pstrb !== 4'b1111) begin
            errors++; $display("FAIL wr_pstrb: got %b, required 1111", s_pstrb);
        end
        checks++;
        if (s_pwdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_pwdata: got %h, required deadbeef", s_pwdata);
        end
        checks++;
        if (s_pprot !== 3'b011 || s_pwrite !== 1'b1) begin
            errors++; $display("FAIL wr_pprot_pwrite: got %b %b, required 011 1", s_pprot, s_pwrite);
        end
        checks++;
        if (x_resp !== 1'b0 || x_err_low !== 0) begin
            errors++; $display("FAIL wr_resp: end hresp=%b err cycles=%0d, required 0 0", x_resp, x_err_low);
        end
    endtask

    logic [31:0] v_addr [5] = '{32'h3, 32'h2, 32'h1, 32'h3, 32'h0};
    logic [2:0]  v_size [5] = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd1};
    logic [3:0]  v_strb [5] = '{4'b1000, 4'b1100, 4'b0010, 4'b1100, 4'b0011};

    task test_strobes;
        for (int i = 0; i < 5; i++) begin
            do_xfer(v_addr[i], 1'b1, v_size[i], 4'b0011, 32'hAB000000);
            checks++;
            if (s_pstrb !== v_strb[i] || x_low !== 3) begin
                errors++;
                $display("FAIL strobe_%0d: pstrb=%b low=%0d, required %b 3", i, s_pstrb, x_low, v_strb[i]);
            end
        end
    endtask

    task test_read_stall;
        stall_cfg = 3;
        rdata_cfg = 32'h12345678;
        do_xfer(32'h2C, 1'b0, 3'd2, 4'b0000, 32'h0);
        stall_cfg = 0;
        checks++;
        if (x_low !== 5 || x_acc !== 4) begin
            errors++; $display("FAIL rd_wait: low=%0d access=%0d, required 5 4", x_low, x_acc);
        end
        checks++;
        if (x_rdata !== 32'h12345678) begin
            errors++; $display("FAIL rd_hrdata: got %h, required 12345678", x_rdata);
        end
        checks++;
        if (s_paddr !== 10'h02C || s_pwrite !== 1'b0 || s_pstrb !== 4'b0000 || s_pprot !== 3'b110) begin
            errors++;
            $display("FAIL rd_setup: paddr=%h pwrite=%b pstrb=%b pprot=%b, required 02c 0 0000 110",
                     s_paddr, s_pwrite, s_pstrb, s_pprot);
        end
        rdata_cfg = 32'hFFFF0000;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.hrdata !== 32'h12345678) begin
            errors++; $display("FAIL rd_hold: hrdata=%h, required 12345678", bus.hrdata);
        end
    endtask

    task test_slverr;
        err_cfg = 1'b1;
        do_xfer(32'h40, 1'b0, 3'd2, 4'b0010, 32'h0);
        err_cfg = 1'b0;
        checks++;
        if (x_low !== 3 || x_err_low !== 1 || x_resp !== 1'b1) begin
            errors++;
            $display("FAIL slverr_resp: low=%0d err_low=%0d end hresp=%b, required 3 1 1", x_low, x_err_low, x_resp);
        end
        checks++;
        if (x_rdata !== 32'h12345678) begin
            errors++; $display("FAIL slverr_hrdata: got %h, required 12345678", x_rdata);
        end
        @(negedge clk);
        checks++;
        if (bus.hresp !== 1'b0 || bus.hreadyout !== 1'b1) begin
            errors++; $display("FAIL slverr_after: hresp=%b hreadyout=%b, required 0 1", bus.hresp, bus.hreadyout);
        end
    endtask

    task test_size_err;
        do_xfer(32'h80, 1'b1, 3'd3, 4'b0011, 32'h11111111);
        checks++;
        if (x_saw_psel !== 1'b0) begin
            errors++; $display("FAIL size_err_psel: psel seen=%b, required 0", x_saw_psel);
        end
        checks++;
        if (x_low !== 1 || x_err_low !== 1 || x_resp !== 1'b1) begin
            errors++;
            $display("FAIL size_err_resp: low=%0d err_low=%0d end hresp=%b, required 1 1 1", x_low, x_err_low, x_resp);
        end
        @(negedge clk);
    endtask

    task test_idle_busy;
        bus.hsel   = 1'b1;
        bus.htrans = 2'b01;
        @(negedge clk);
        checks++;
        if (bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0 || bus.psel !== 1'b0) begin
            errors++;
            $display("FAIL busy_okay: hreadyout=%b hresp=%b psel=%b, required 1 0 0", bus.hreadyout, bus.hresp, bus.psel);
        end
        bus.htrans = 2'b00;
        @(negedge clk);
        checks++;
        if (bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0 || bus.psel !== 1'b0) begin
            errors++;
            $display("FAIL idle_okay: hreadyout=%b hresp=%b psel=%b, required 1 0 0", bus.hreadyout, bus.hresp, bus.psel);
        end
        bus.hsel = 1'b0;
    endtask

    task test_back_to_back;
        rdata_cfg = 32'hCAFEF00D;
        do_xfer(32'h10, 1'b1, 3'd2, 4'b0011, 32'h0BADF00D);
        checks++;
        if (x_low !== 3 || s_pwdata !== 32'h0BADF00D) begin
            errors++; $display("FAIL b2b_first: low=%0d pwdata=%h, required 3 0badf00d", x_low, s_pwdata);
        end
        do_xfer(32'h20, 1'b0, 3'd2, 4'b0011, 32'h0);
        checks++;
        if (x_first_setup !== 1'b1 || s_paddr !== 10'h020) begin
            errors++;
            $display("FAIL b2b_setup: immediate setup=%b paddr=%h, required 1 020", x_first_setup, s_paddr);
        end
        checks++;
        if (x_low !== 2 || x_rdata !== 32'hCAFEF00D) begin
            errors++; $display("FAIL b2b_read: low=%0d hrdata=%h, required 2 cafef00d", x_low, x_rdata);
        end
    endtask

    task test_reset_mid;
        stuck      = 1'b1;
        bus.hsel   = 1'b1;
        bus.haddr  = 32'h30;
        bus.hwrite = 1'b0;
        bus.hsize  = 3'd2;
        bus.htrans = 2'b10;
        @(negedge clk);
        bus.hsel   = 1'b0;
        bus.htrans = 2'b00;
        @(negedge clk);
        checks++;
        if (bus.psel !== 1'b1 || bus.penable !== 1'b1 || bus.hreadyout !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_access: psel=%b penable=%b hreadyout=%b, required 1 1 0",
                     bus.psel, bus.penable, bus.hreadyout);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.psel !== 1'b0 || bus.penable !== 1'b0 || bus.hreadyout !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_abort: psel=%b penable=%b hreadyout=%b, required 0 0 1",
                     bus.psel, bus.penable, bus.hreadyout);
        end
        stuck = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

`ifdef AHB3LITE_APB_TIMEOUT_EN
    task test_timeout;
        stuck = 1'b1;
        do_xfer(32'h34, 1'b0, 3'd2, 4'b0011, 32'h0);
        stuck = 1'b0;
        checks++;
        if (x_acc !== TMO || x_low !== TMO + 2) begin
            errors++; $display("FAIL tmo_len: access=%0d low=%0d, required %0d %0d", x_acc, x_low, TMO, TMO + 2);
        end
        checks++;
        if (x_err_low !== 1 || x_resp !== 1'b1) begin
            errors++; $display("FAIL tmo_resp: err_low=%0d end hresp=%b, required 1 1", x_err_low, x_resp);
        end
        @(negedge clk);
        checks++;
        if (bus.psel !== 1'b0 || bus.hresp !== 1'b0) begin
            errors++; $display("FAIL tmo_after: psel=%b hresp=%b, required 0 0", bus.psel, bus.hresp);
        end
    endtask
`else
    task test_timeout;
        stuck      = 1'b1;
        bus.hsel   = 1'b1;
        bus.haddr  = 32'h34;
        bus.hwrite = 1'b0;
        bus.hsize  = 3'd2;
        bus.htrans = 2'b10;
        @(negedge clk);
        bus.hsel   = 1'b0;
        bus.htrans = 2'b00;
        repeat (1000) @(negedge clk);
        checks++;
        if (bus.psel !== 1'b1 || bus.penable !== 1'b1 || bus.hreadyout !== 1'b0) begin
            errors++;
            $display("FAIL no_tmo_wait: psel=%b penable=%b hreadyout=%b, required 1 1 0",
                     bus.psel, bus.penable, bus.hreadyout);
        end
        stuck = 1'b0;
        for (int c = 0; c < 10 && bus.hreadyout !== 1'b1; c++) @(negedge clk);
        checks++;
        if (bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0 || bus.psel !== 1'b0) begin
            errors++;
            $display("FAIL no_tmo_release: hreadyout=%b hresp=%b psel=%b, required 1 0 0",
                     bus.hreadyout, bus.hresp, bus.psel);
        end
    endtask
`endif

    initial begin
        bus.hsel      = 1'b0;
        bus.haddr     = '0;
        bus.hwdata    = '0;
        bus.hwrite    = 1'b0;
        bus.hsize     = 3'd0;
        bus.hburst    = 3'd0;
        bus.hprot     = 4'd0;
        bus.htrans    = 2'b00;
        bus.hmastlock = 1'b0;

        test_reset();
        test_word_write();
        test_strobes();
        test_read_stall();
        test_slverr();
        test_size_err();
        test_idle_busy();
        test_back_to_back();
        test_reset_mid();
        test_timeout();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
